// File: rtl/tag_anc_pkg.sv
// rtl/tag_anc_pkg.sv - shared tag encodings, LFSR constants and helpers
package tag_anc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PREAMBLE = 2'b01,
    ST_SYNC     = 2'b10,
    ST_LOC_TX   = 2'b11
  } tx_state_t;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right: taps land on bits 0,2,3,5
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int AMP_DEFAULT = 16384;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tag_tx_ctrl_if.sv
// rtl/tag_tx_ctrl_if.sv - I/Q sample and DDS phase stream bundle
interface tag_tx_ctrl_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 24
) ();
  logic [DATA_WIDTH-1:0]  out_itdata;
  logic [DATA_WIDTH-1:0]  out_qtdata;
  logic                   out_tvalid;
  logic                   out_tready;
  logic [PHASE_WIDTH-1:0] ph_tdata;

  modport master (
    output out_itdata, out_qtdata, out_tvalid, ph_tdata,
    input  out_tready
  );

  modport slave (
    input  out_itdata, out_qtdata, out_tvalid, ph_tdata,
    output out_tready
  );
endinterface

// File: rtl/tag_tx_lfsr.sv
// rtl/tag_tx_lfsr.sv - preamble PN generator with seed reload
module tag_tx_lfsr
  import tag_anc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic advance,
  output logic bit0
);

  logic [15:0] lfsr;

  // Seed reload has priority over advancing so period boundaries restart the sequence
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (load) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end
  end

  assign bit0 = lfsr[0];

endmodule

// File: rtl/tag_tx_ctrl.sv
// rtl/tag_tx_ctrl.sv - tag transmit sequencer (preamble, sync, tone frames); TAG_TX_GPIO_EN enables front-panel GPIO
module tag_tx_ctrl
  import tag_anc_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int PHASE_WIDTH   = 24,
  parameter int PRMB_LEN      = 64,
  parameter int NPRMB_REP     = 64,
  parameter int NSYNCP        = 16384,
  parameter int NSYNCN        = 16384,
  parameter int NSYMB         = 64,
  parameter int NSIG          = 262144,
  parameter int NLOC_PER_SYNC = 7,
  parameter logic [PHASE_WIDTH-1:0] START_PH_INC = PHASE_WIDTH'(4194304),
  parameter logic [PHASE_WIDTH-1:0] DPH_INC      = PHASE_WIDTH'(-131072),
  parameter int AMP           = AMP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_tx,
  tag_tx_ctrl_if.master tx,
  output logic        tone_en,
  output logic [1:0]  tx_state,
  output logic        frame_stb,
  output logic [11:0] fp_gpio_out,
  output logic [11:0] fp_gpio_ddr
);

  localparam int CNT_W = $clog2(max3(PRMB_LEN*NPRMB_REP, NSYNCP+NSYNCN, NSIG) + 1);
  localparam int PRD_W = $clog2(PRMB_LEN + 1);
  localparam int SYM_W = $clog2(NSYMB + 1);
  localparam int FRM_W = $clog2(NLOC_PER_SYNC + 1);
  localparam logic [DATA_WIDTH-1:0] AMP_P = DATA_WIDTH'(AMP);
  localparam logic [DATA_WIDTH-1:0] AMP_N = DATA_WIDTH'(-AMP);

  tx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PRD_W-1:0]       prd_q, prd_d;
  logic [SYM_W-1:0]       sym_q, sym_d;
  logic [FRM_W-1:0]       frm_q, frm_d;
  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [PHASE_WIDTH-1:0] inc_q, inc_d;
  logic                   beat;
  logic                   prd_end;
  logic                   lfsr_bit;

  assign beat    = tx.out_tvalid & tx.out_tready;
  assign prd_end = (prd_q == PRD_W'(PRMB_LEN - 1));

  tag_tx_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (!run_tx || (beat && state_q == ST_PREAMBLE && prd_end)),
    .advance (beat && state_q == ST_PREAMBLE),
    .bit0    (lfsr_bit)
  );

  // State and sequencing counters; run_tx low returns everything to reset values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prd_q   <= '0;
      sym_q   <= '0;
      frm_q   <= '0;
      acc_q   <= '0;
      inc_q   <= START_PH_INC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prd_q   <= prd_d;
      sym_q   <= sym_d;
      frm_q   <= frm_d;
      acc_q   <= acc_d;
      inc_q   <= inc_d;
    end
  end

  // Next-state logic: everything past IDLE moves only on an accepted beat
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prd_d   = prd_q;
    sym_d   = sym_q;
    frm_d   = frm_q;
    acc_d   = acc_q;
    inc_d   = inc_q;
    if (!run_tx) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      prd_d   = '0;
      sym_d   = '0;
      frm_d   = '0;
      acc_d   = '0;
      inc_d   = START_PH_INC;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_PREAMBLE;
        ST_PREAMBLE: if (beat) begin
          prd_d = prd_end ? '0 : prd_q + 1'b1;
          if (cnt_q == CNT_W'(PRMB_LEN*NPRMB_REP - 1)) begin
            cnt_d   = '0;
            state_d = ST_SYNC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SYNC: if (beat) begin
          if (cnt_q == CNT_W'(NSYNCP + NSYNCN - 1)) begin
            cnt_d   = '0;
            state_d = ST_LOC_TX;
            acc_d   = '0;
            inc_d   = START_PH_INC;
            sym_d   = '0;
            frm_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_LOC_TX: if (beat) begin
          acc_d = acc_q + inc_q;
          if (cnt_q == CNT_W'(NSIG - 1)) begin
            cnt_d = '0;
            if (sym_q == SYM_W'(NSYMB - 1)) begin
              sym_d = '0;
              inc_d = START_PH_INC;
              if (frm_q == FRM_W'(NLOC_PER_SYNC - 1)) begin
                frm_d   = '0;
                state_d = ST_PREAMBLE;
              end else begin
                frm_d = frm_q + 1'b1;
              end
            end else begin
              sym_d = sym_q + 1'b1;
              inc_d = inc_q + DPH_INC;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so they hold while the sink stalls
  always_comb begin
    tx.out_itdata = '0;
    case (state_q)
      ST_PREAMBLE: tx.out_itdata = lfsr_bit ? AMP_P : AMP_N;
      ST_SYNC:     tx.out_itdata = (cnt_q < CNT_W'(NSYNCP)) ? AMP_P : AMP_N;
      default:     tx.out_itdata = '0;
    endcase
  end

  assign tx.out_qtdata = '0;
  assign tx.out_tvalid = (state_q != ST_IDLE);
  assign tone_en       = (state_q == ST_LOC_TX);
  assign tx.ph_tdata   = tone_en ? acc_q : '0;
  assign tx_state      = state_q;
  assign frame_stb     = beat && (state_q == ST_PREAMBLE) && (cnt_q == '0);

`ifdef TAG_TX_GPIO_EN
  logic [11:0] gpio_q;

  // Front-panel markers for scope triggering: bit0 during sync, bit4 during tones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_q <= '0;
    end else begin
      gpio_q <= {7'b0, tone_en, 3'b0, (state_q == ST_SYNC)};
    end
  end

  assign fp_gpio_out = gpio_q;
  assign fp_gpio_ddr = 12'h011;
`else
  assign fp_gpio_out = '0;
  assign fp_gpio_ddr = '0;
`endif

endmodule

// File: tb/tb_tag_tx_ctrl.sv
// tb/tb_tag_tx_ctrl.sv - scoreboard bench for tag_tx_ctrl
module tb_tag_tx_ctrl;

  localparam logic [15:0] AP = 16'h4000;
  localparam logic [15:0] AN = 16'hC000;

  typedef struct packed {
    logic [15:0] i;
    logic [23:0] ph;
    logic        tone;
    logic        stb;
    logic [1:0]  st;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run_tx = 1'b0;
  logic run_w = 1'b0;
  logic tone_en, frame_stb, tone_w, stb_w;
  logic [1:0] tx_state, st_w;
  logic [11:0] gpio_out, gpio_ddr, gpio_out_w, gpio_ddr_w;

  int tests = 0;
  int fails = 0;
  exp_t sbq[$];
  exp_t e;
  logic [23:0] loc_ph [12] = '{24'h000000, 24'h100000, 24'h200000, 24'h300000,
                               24'h410000, 24'h520000, 24'h630000, 24'h730000,
                               24'h830000, 24'h930000, 24'hA40000, 24'hB50000};

  tag_tx_ctrl_if #(.DATA_WIDTH(16), .PHASE_WIDTH(24)) m_if ();
  tag_tx_ctrl_if #(.DATA_WIDTH(16), .PHASE_WIDTH(24)) w_if ();

  assign w_if.out_tready = 1'b1;

  tag_tx_ctrl #(
    .PRMB_LEN(4), .NPRMB_REP(2), .NSYNCP(3), .NSYNCN(2), .NSYMB(2), .NSIG(3),
    .NLOC_PER_SYNC(2), .START_PH_INC(24'h100000), .DPH_INC(24'h010000)
  ) dut (
    .clk(clk), .reset(reset), .run_tx(run_tx), .tx(m_if),
    .tone_en(tone_en), .tx_state(tx_state), .frame_stb(frame_stb),
    .fp_gpio_out(gpio_out), .fp_gpio_ddr(gpio_ddr)
  );

  tag_tx_ctrl #(
    .PRMB_LEN(4), .NPRMB_REP(2), .NSYNCP(3), .NSYNCN(2), .NSYMB(2), .NSIG(3),
    .NLOC_PER_SYNC(2), .START_PH_INC(24'hF00000), .DPH_INC(24'h010000)
  ) dut_wrap (
    .clk(clk), .reset(reset), .run_tx(run_w), .tx(w_if),
    .tone_en(tone_w), .tx_state(st_w), .frame_stb(stb_w),
    .fp_gpio_out(gpio_out_w), .fp_gpio_ddr(gpio_ddr_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] i, input logic [23:0] ph, input logic tone,
                      input logic stb, input logic [1:0] st);
    exp_t x;
    x.i = i; x.ph = ph; x.tone = tone; x.stb = stb; x.st = st;
    sbq.push_back(x);
  endtask

  task automatic push_pre(input int n);
    for (int k = 0; k < n; k++) push((k % 4 == 0) ? AP : AN, 24'h0, 1'b0, k == 0, 2'b01);
  endtask

  task automatic push_sync(input int n);
    for (int k = 0; k < n; k++) push((k < 3) ? AP : AN, 24'h0, 1'b0, 1'b0, 2'b10);
  endtask

  task automatic push_loc(input int n);
    for (int k = 0; k < n; k++) push(16'h0, loc_ph[k], 1'b1, 1'b0, 2'b11);
  endtask

  // Wait for the scoreboard to empty; returns 1 ns after the edge that took the last beat
  task automatic drain(input string name, input bit rnd);
    for (int k = 0; k < 2000 && sbq.size() != 0; k++) begin
      @(posedge clk);
      #1;
      if (rnd) m_if.out_tready = 1'($urandom_range(0, 1));
    end
    check(name, sbq.size(), 0);
    m_if.out_tready = 1'b1;
  endtask

  task automatic restart;
    run_tx = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted beat is popped and compared against the scoreboard
  always @(negedge clk) begin
    if (!reset && run_tx && m_if.out_tvalid && m_if.out_tready) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got beat i=%h state=%0d expected none", m_if.out_itdata, tx_state);
      end else begin
        e = sbq.pop_front();
        check("beat_i", 32'(m_if.out_itdata), 32'(e.i));
        check("beat_q", 32'(m_if.out_qtdata), 32'h0);
        check("beat_ph", 32'(m_if.ph_tdata), 32'(e.ph));
        check("beat_tone", 32'(tone_en), 32'(e.tone));
        check("beat_stb", 32'(frame_stb), 32'(e.stb));
        check("beat_state", 32'(tx_state), 32'(e.st));
      end
    end
  end

  initial begin
    m_if.out_tready = 1'b1;
    #3;
    check("rst_valid", 32'(m_if.out_tvalid), 0);
    check("rst_state", 32'(tx_state), 0);
    check("rst_i", 32'(m_if.out_itdata), 0);
    check("rst_ph", 32'(m_if.ph_tdata), 0);
    check("rst_tone", 32'(tone_en), 0);
    check("rst_stb", 32'(frame_stb), 0);
    check("rst_gpio", 32'(gpio_out), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_valid", 32'(m_if.out_tvalid), 0);

    // Full sequence with ready held high, through into the next preamble
    push_pre(8);
    push_sync(5);
    push_loc(12);
    push_pre(1);
    run_tx = 1'b1;
    #1 check("pre_rise_valid", 32'(m_if.out_tvalid), 0);
    @(posedge clk);
    #1;
    check("latency_valid", 32'(m_if.out_tvalid), 1);
    check("latency_state", 32'(tx_state), 1);
    drain("drain_full", 1'b0);

    // Same stream under random backpressure
    restart();
    push_pre(8);
    push_sync(5);
    push_loc(12);
    push_pre(1);
    run_tx = 1'b1;
    drain("drain_random", 1'b1);

    // Drop run_tx in the middle of sync, then restart from preamble sample 0
    restart();
    push_pre(8);
    push_sync(2);
    run_tx = 1'b1;
    drain("drain_to_sync", 1'b0);
    check("in_sync_state", 32'(tx_state), 2);
    run_tx = 1'b0;
    @(posedge clk);
    #1;
    check("clr_valid", 32'(m_if.out_tvalid), 0);
    check("clr_state", 32'(tx_state), 0);
    check("clr_i", 32'(m_if.out_itdata), 0);
    push_pre(4);
    run_tx = 1'b1;
    drain("drain_reraise", 1'b0);

    // Asynchronous reset in the middle of tone transmission
    restart();
    push_pre(8);
    push_sync(5);
    push_loc(3);
    run_tx = 1'b1;
    drain("drain_to_loc", 1'b0);
    check("in_loc_tone", 32'(tone_en), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(m_if.out_tvalid), 0);
    check("arst_tone", 32'(tone_en), 0);
    check("arst_ph", 32'(m_if.ph_tdata), 0);
    check("arst_state", 32'(tx_state), 0);
    check("arst_i", 32'(m_if.out_itdata), 0);
    check("arst_stb", 32'(frame_stb), 0);
    run_tx = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Phase accumulator wrap with a large starting increment
    run_w = 1'b1;
    for (int k = 0; k < 100 && !tone_w; k++) begin
      @(posedge clk);
      #1;
    end
    check("wrap_tone", 32'(tone_w), 1);
    check("wrap_ph0", 32'(w_if.ph_tdata), 32'h000000);
    @(posedge clk);
    #1 check("wrap_ph1", 32'(w_if.ph_tdata), 32'hF00000);
    @(posedge clk);
    #1 check("wrap_ph2", 32'(w_if.ph_tdata), 32'hE00000);
    run_w = 1'b0;

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tag_tx_ctrl.md
TAG_TX_CTRL -- requirements
Module: tag_tx_ctrl

Interface
REQ-001 DATA_WIDTH, 16, I/Q sample width.
REQ-002 PHASE_WIDTH, 24, phase accumulator/increment width.
REQ-003 PRMB_LEN, 64, preamble period in samples.
REQ-004 NPRMB_REP, 64, preamble periods per preamble.
REQ-005 NSYNCP, 16384, positive sync samples.
REQ-006 NSYNCN, 16384, negative sync samples.
REQ-007 NSYMB, 64, tone symbols per localization frame.
REQ-008 NSIG, 262144, samples per tone symbol.
REQ-009 NLOC_PER_SYNC, 7, localization frames between preambles.
REQ-010 START_PH_INC, 24'd4194304, phase increment of symbol 0.
REQ-011 DPH_INC, -131072, per-symbol increment step, two's complement.
REQ-012 AMP, 16384, preamble/sync amplitude.
REQ-013 clk  in  1  sole clock; all logic on rising edge.
REQ-014 reset  in  1  asynchronous, active-high reset.
REQ-015 run_tx  in  1  enable; low acts as synchronous clear.
REQ-016 out_itdata  out  DATA_WIDTH  I sample, two's complement.
REQ-017 out_qtdata  out  DATA_WIDTH  Q sample.
REQ-018 out_tvalid  out  1  sample/phase valid.
REQ-019 out_tready  in  1  downstream ready.
REQ-020 ph_tdata  out  PHASE_WIDTH  phase word for downstream DDS.
REQ-021 tone_en  out  1  high in LOC_TX; downstream uses DDS output instead of I/Q.
REQ-022 tx_state  out  2  current state encoding.
REQ-023 frame_stb  out  1  one-cycle pulse on first preamble beat.
REQ-024 fp_gpio_out / fp_gpio_ddr  out  12 each  front-panel GPIO value/direction.

Function
REQ-025 States: IDLE=2'b00, PREAMBLE=2'b01, SYNC=2'b10, LOC_TX=2'b11; tx_state equals state register.
REQ-026 Beat = out_tvalid & out_tready; counters, LFSR, accumulator and state advance only on a beat; all outputs held stable otherwise (no drop, no repeat).
REQ-027 IDLE: out_tvalid=0, data outputs 0; run_tx=1 -> PREAMBLE next cycle with out_tvalid=1; latency run_tx rise to first valid sample = 1 cycle.
REQ-028 PREAMBLE: Q=0; I=+AMP if LFSR bit0=1 else -AMP; 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1, seed 16'hACE1 reloaded at start of every PRMB_LEN period; after PRMB_LEN*NPRMB_REP beats -> SYNC.
REQ-029 SYNC: Q=0; I=+AMP for NSYNCP beats, then -AMP for NSYNCN beats; then -> LOC_TX with accumulator=0, increment=START_PH_INC, symbol and frame counts 0.
REQ-030 LOC_TX: tone_en=1, I=Q=0, ph_tdata=accumulator before add; accumulator += increment per beat, modulo 2^PHASE_WIDTH; after NSIG beats increment += DPH_INC (modulo) and symbol count increments; accumulator never reset inside LOC_TX.
REQ-031 After NSYMB symbols a frame ends; increment reloads START_PH_INC; after NLOC_PER_SYNC frames -> PREAMBLE (LFSR reseeded, frame_stb pulses).
REQ-032 Sample counter width = clog2 of max(PRMB_LEN*NPRMB_REP, NSYNCP+NSYNCN, NSIG)+1.
REQ-033 run_tx low in any state, including mid-beat: next cycle IDLE, all registers at reset values, pending sample discarded; re-raise restarts at preamble sample 0.

Reset
REQ-034 reset asserts asynchronously: state IDLE, out_tvalid/tone_en/frame_stb/data/ph_tdata/fp_gpio_out 0, LFSR 16'hACE1, increment START_PH_INC, counters 0; release synchronous to clk.

Configuration
REQ-035 TAG_TX_GPIO_EN defined: fp_gpio_ddr=12'h011, fp_gpio_out bit0 = (state==SYNC), bit4 = tone_en, registered one cycle; undefined: both outputs constant 0, no GPIO logic.

Structure
REQ-036 Package tag_anc_pkg holds state encodings, LFSR seed and taps, default AMP; shared with the receive side.
REQ-037 One sub-module tag_tx_lfsr (load, advance, bit0 output); rest flat.

Verification (PRMB_LEN=4, NPRMB_REP=2, NSYNCP=3, NSYNCN=2, NSYMB=2, NSIG=3, NLOC_PER_SYNC=2, START_PH_INC=24'h100000, DPH_INC=24'h010000)
REQ-038 run_tx=1, ready=1 -> frame_stb one cycle; 8 preamble I values, period 4 identical, first +AMP; then I=+AMP x3, -AMP x2, Q=0.
REQ-039 Continue -> ph_tdata 0,100000,200000,300000,410000,520000; frame 2 starts 630000,730000; after frame 2 tx_state=01.
REQ-040 Random 50% out_tready -> accepted-beat stream identical to REQ-038/039 stream.
REQ-041 run_tx low during SYNC -> next cycle out_tvalid=0, tx_state=00; re-raise -> frame_stb, preamble sample 0.
REQ-042 reset pulsed mid-LOC_TX between clock edges -> all outputs 0 immediately.
REQ-043 START_PH_INC=24'hF00000 -> ph_tdata 0,F00000,E00000 (wrap).
